// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: per-channel FIFOs sharing one UART TX, grant locked for a whole packet.
// Define UART_ARB_RR_EN for round-robin channel selection; fixed priority (ch0 highest) otherwise.
module uart_tx_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] i_wr_data,
    input  logic [NUM_CH-1:0]        i_wr_last,
    input  logic [NUM_CH-1:0]        i_wr_en,
    input  logic                     i_tx_busy,
    output logic [DATA_W-1:0]        o_tx_data,
    output logic                     o_tx_start,
    output logic [NUM_CH-1:0]        o_full,
    output logic [NUM_CH-1:0]        o_empty,
    output logic [NUM_CH-1:0]        o_ovf,
    output logic [NUM_CH-1:0]        o_grant,
    output logic                     o_active
);
    localparam int CW    = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int EW    = DATA_W + 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;
    state_t r_state, w_state_nx;

    logic [CW-1:0]        r_gidx, w_sel;
    logic [NUM_CH-1:0]    r_grant, r_ovf;
    logic [DATA_W-1:0]    r_data;
    logic                 r_start, r_last, w_pop, w_done;
    logic [NUM_CH*EW-1:0] w_head;
    logic [EW-1:0]        w_head_g;
`ifdef UART_ARB_RR_EN
    logic [CW-1:0]        r_rr;
`endif

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_ch
            logic [EW-1:0]      r_mem [DEPTH];
            logic [FIFO_AW-1:0] r_wp, r_rp;
            logic [FIFO_AW:0]   r_cnt;
            logic               w_push, w_popk;
            assign w_push = i_wr_en[k] && !o_full[k];
            assign w_popk = w_pop && r_gidx == CW'(k);
            assign o_full[k]  = r_cnt == (FIFO_AW+1)'(DEPTH);
            assign o_empty[k] = r_cnt == '0;
            assign w_head[k*EW +: EW] = r_mem[r_rp];
            always_ff @(posedge clk) begin
                if (w_push) r_mem[r_wp] <= {i_wr_last[k], i_wr_data[k*DATA_W +: DATA_W]};
            end
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_wp  <= '0;
                    r_rp  <= '0;
                    r_cnt <= '0;
                end else begin
                    if (w_push) r_wp <= r_wp + 1'b1;
                    if (w_popk) r_rp <= r_rp + 1'b1;
                    if (w_push != w_popk) r_cnt <= w_push ? r_cnt + 1'b1 : r_cnt - 1'b1;
                end
            end
        end
    endgenerate

    assign w_head_g = w_head[int'(r_gidx)*EW +: EW];

    // Scan from the highest candidate down so the preferred channel is written last.
    always_comb begin
        w_sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
`ifdef UART_ARB_RR_EN
            int j;
            j = int'(r_rr) + i;
            if (j >= NUM_CH) j -= NUM_CH;
            if (!o_empty[CW'(j)]) w_sel = CW'(j);
`else
            if (!o_empty[CW'(i)]) w_sel = CW'(i);
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        case (r_state)
            IDLE:    if (|(~o_empty)) w_state_nx = SEND;
            SEND:    if (!i_tx_busy && !o_empty[r_gidx]) begin
                         w_pop      = 1'b1;
                         w_state_nx = WAIT_HI;
                     end
            WAIT_HI: if (i_tx_busy) w_state_nx = WAIT_LO;
            WAIT_LO: if (!i_tx_busy) w_state_nx = r_last ? IDLE : SEND;
            default: w_state_nx = IDLE;
        endcase
    end

    assign w_done = r_state == WAIT_LO && !i_tx_busy && r_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gidx  <= '0;
            r_grant <= '0;
            r_data  <= '0;
            r_start <= 1'b0;
            r_last  <= 1'b0;
            r_ovf   <= '0;
`ifdef UART_ARB_RR_EN
            r_rr    <= '0;
`endif
        end else begin
            r_start <= w_pop;
            r_ovf   <= i_wr_en & o_full;
            if (r_state == IDLE && |(~o_empty)) begin
                r_gidx  <= w_sel;
                r_grant <= NUM_CH'(1) << w_sel;
            end
            if (w_pop) {r_last, r_data} <= w_head_g;
            if (w_done) begin
                r_grant <= '0;
`ifdef UART_ARB_RR_EN
                r_rr    <= (int'(r_gidx) == NUM_CH - 1) ? '0 : r_gidx + 1'b1;
`endif
            end
        end
    end

    assign o_tx_data  = r_data;
    assign o_tx_start = r_start;
    assign o_ovf      = r_ovf;
    assign o_grant    = r_grant;
    assign o_active   = r_state != IDLE;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a simple UART busy model.
// Expectations for the arbitration-order case follow UART_ARB_RR_EN.
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] i_wr_data = '0;
    logic [1:0]  i_wr_last = '0;
    logic [1:0]  i_wr_en = '0;
    logic        busy;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic [1:0]  o_full, o_empty, o_ovf, o_grant;
    logic        o_active;

    int         checks = 0;
    int         errors = 0;
    int         bcnt = 0;
    int         blen = 20;
    logic       hold = 1'b0;
    int         starts = 0;
    logic [7:0] log_d[$];
    logic [1:0] log_g[$];

    uart_tx_arbiter #(.NUM_CH(2), .DATA_W(8), .FIFO_AW(4)) dut (
        .clk(clk), .reset(reset), .i_wr_data(i_wr_data), .i_wr_last(i_wr_last),
        .i_wr_en(i_wr_en), .i_tx_busy(busy), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
        .o_full(o_full), .o_empty(o_empty), .o_ovf(o_ovf), .o_grant(o_grant), .o_active(o_active)
    );

    always #5 clk = ~clk;

    assign busy = hold || bcnt != 0;

    always @(posedge clk) begin
        if (reset) bcnt <= 0;
        else if (o_tx_start) bcnt <= blen;
        else if (bcnt != 0) bcnt <= bcnt - 1;
        if (!reset && o_tx_start) begin
            log_d.push_back(o_tx_data);
            log_g.push_back(o_grant);
            starts <= starts + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] en, input logic [15:0] d, input logic [1:0] l);
        @(negedge clk);
        i_wr_en   = en;
        i_wr_data = d;
        i_wr_last = l;
    endtask

    task automatic release_wr;
        @(negedge clk);
        i_wr_en = 2'b00;
    endtask

    task automatic wait_done(input int n, input string tag);
        int t;
        t = 0;
        while ((log_d.size() < n || o_active || busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(t < 3000), 1);
    endtask

    logic [7:0] exp2[5] = '{8'h31, 8'h32, 8'h3A, 8'h41, 8'h42};
    logic [1:0] gnt2[5] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
`ifdef UART_ARB_RR_EN
    logic [7:0] exp3[4] = '{8'h61, 8'h63, 8'h62, 8'h64};
`else
    logic [7:0] exp3[4] = '{8'h61, 8'h62, 8'h63, 8'h64};
`endif
    logic [7:0] exp5[4] = '{8'h58, 8'h59, 8'h5A, 8'h51};
    logic [1:0] gnt5[4] = '{2'b01, 2'b01, 2'b01, 2'b10};

    initial begin
        int b, s, t;
        repeat (3) @(negedge clk);
        check("rst_active", 32'(o_active), 0);
        check("rst_grant", 32'(o_grant), 0);
        check("rst_start", 32'(o_tx_start), 0);
        check("rst_data", 32'(o_tx_data), 0);
        check("rst_empty", 32'(o_empty), 'h3);
        check("rst_full", 32'(o_full), 0);
        check("rst_ovf", 32'(o_ovf), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        drive(2'b10, {8'h41, 8'h00}, 2'b10);
        @(negedge clk);
        i_wr_en = 2'b00;
        check("t1_n1_grant", 32'(o_grant), 0);
        check("t1_n1_empty", 32'(o_empty), 'h1);
        @(negedge clk);
        check("t1_n2_grant", 32'(o_grant), 'h2);
        check("t1_n2_start", 32'(o_tx_start), 0);
        @(negedge clk);
        check("t1_n3_start", 32'(o_tx_start), 1);
        check("t1_n3_data", 32'(o_tx_data), 'h41);
        @(negedge clk);
        check("t1_n4_start", 32'(o_tx_start), 0);
        check("t1_n4_data", 32'(o_tx_data), 'h41);
        wait_done(1, "t1_timeout");
        @(negedge clk);
        check("t1_idle_grant", 32'(o_grant), 0);
        check("t1_idle_active", 32'(o_active), 0);
        check("t1_idle_empty", 32'(o_empty), 'h3);
        check("t1_log_g", 32'(log_g[0]), 'h2);

        blen = 3;
        b = log_d.size();
        drive(2'b11, {8'h41, 8'h31}, 2'b00);
        drive(2'b11, {8'h42, 8'h32}, 2'b10);
        drive(2'b01, {8'h00, 8'h3A}, 2'b01);
        release_wr();
        wait_done(b + 5, "t2_timeout");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_d%0d", i), 32'(log_d[b+i]), 32'(exp2[i]));
            check($sformatf("t2_g%0d", i), 32'(log_g[b+i]), 32'(gnt2[i]));
        end

        b = log_d.size();
        drive(2'b11, {8'h63, 8'h61}, 2'b11);
        drive(2'b11, {8'h64, 8'h62}, 2'b11);
        release_wr();
        wait_done(b + 4, "t3_timeout");
        for (int i = 0; i < 4; i++) check($sformatf("t3_d%0d", i), 32'(log_d[b+i]), 32'(exp3[i]));

        hold = 1'b1;
        b = log_d.size();
        for (int i = 0; i < 16; i++) drive(2'b01, {8'h00, 8'(16 + i)}, (i == 15) ? 2'b01 : 2'b00);
        @(negedge clk);
        i_wr_en = 2'b00;
        check("t4_full16", 32'(o_full), 'h1);
        check("t4_ovf16", 32'(o_ovf), 0);
        drive(2'b01, {8'h00, 8'h20}, 2'b00);
        @(negedge clk);
        i_wr_en = 2'b00;
        check("t4_ovf17", 32'(o_ovf), 'h1);
        check("t4_full17", 32'(o_full), 'h1);
        @(negedge clk);
        check("t4_ovf_clr", 32'(o_ovf), 0);
        check("t4_nostart", 32'(log_d.size()), 32'(b));
        hold = 1'b0;
        wait_done(b + 16, "t4_timeout");
        for (int i = 0; i < 16; i++) check($sformatf("t4_d%0d", i), 32'(log_d[b+i]), 16 + i);
        check("t4_count", 32'(log_d.size()), 32'(b + 16));
        check("t4_empty", 32'(o_empty), 'h3);

        b = log_d.size();
        drive(2'b01, {8'h00, 8'h58}, 2'b00);
        drive(2'b01, {8'h00, 8'h59}, 2'b00);
        release_wr();
        repeat (20) @(negedge clk);
        drive(2'b10, {8'h51, 8'h00}, 2'b10);
        release_wr();
        repeat (28) @(negedge clk);
        check("t5_gap_grant", 32'(o_grant), 'h1);
        check("t5_gap_count", 32'(log_d.size()), 32'(b + 2));
        drive(2'b01, {8'h00, 8'h5A}, 2'b01);
        release_wr();
        wait_done(b + 4, "t5_timeout");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_d%0d", i), 32'(log_d[b+i]), 32'(exp5[i]));
            check($sformatf("t5_g%0d", i), 32'(log_g[b+i]), 32'(gnt5[i]));
        end

        blen = 20;
        b = log_d.size();
        drive(2'b01, {8'h00, 8'h52}, 2'b00);
        drive(2'b01, {8'h00, 8'h53}, 2'b00);
        drive(2'b01, {8'h00, 8'h54}, 2'b01);
        release_wr();
        t = 0;
        while (log_d.size() < b + 1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t6_first_start", 32'(t < 100), 1);
        repeat (5) @(negedge clk);
        check("t6_pre_active", 32'(o_active), 1);
        reset = 1'b1;
        #1;
        check("t6_active", 32'(o_active), 0);
        check("t6_grant", 32'(o_grant), 0);
        check("t6_start", 32'(o_tx_start), 0);
        check("t6_data", 32'(o_tx_data), 0);
        check("t6_empty", 32'(o_empty), 'h3);
        check("t6_full", 32'(o_full), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        s = starts;
        repeat (40) @(negedge clk);
        check("t6_no_start", 32'(starts), 32'(s));
        check("t6_post_active", 32'(o_active), 0);
        check("t6_post_empty", 32'(o_empty), 'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule
